// File: rtl/out_port_arbiter.sv
// Round-robin arbiter moving one word per cycle from NUM_REQ input buffers into one output buffer.
// Optional per-requester grant counters are enabled with `define ARB_STATS_EN.
module out_port_arbiter #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_empty,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rd_en,
    input  logic                          out_full,
    output logic                          out_wr_en,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          grant_vld,
    output logic                          stall_err,
`ifdef ARB_STATS_EN
    input  logic                          stats_clr,
    output logic [NUM_REQ*16-1:0]         grant_cnt,
`endif
    input  logic                          err_clr
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(STALL_LIMIT + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StXfer  = 2'd1;
    localparam logic [1:0] StStall = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
    logic            stall_err_q, stall_err_d;
    logic [IdxW-1:0] win;
    logic            any_req, go, stall_cond;

    assign any_req    = ~&req_empty;
    // Gating with rst aborts a transfer while reset is asserted mid-cycle.
    assign go         = rst & en & ~out_full & any_req;
    assign stall_cond = en & any_req & out_full;

    always_comb begin
        logic        found;
        int unsigned cand;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!found && !req_empty[cand]) begin
                found = 1'b1;
                win   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        req_rd_en = '0;
        out_data  = '0;
        if (go) begin
            req_rd_en[win] = 1'b1;
            out_data       = req_data[win*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign out_wr_en = go;

    always_comb begin
        ptr_d = ptr_q;
        idx_d = idx_q;
        if (go) begin
            ptr_d = (win == IdxW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            idx_d = win;
        end
    end

    always_comb begin
        if (go) begin
            state_d = StXfer;
        end else if (stall_cond) begin
            state_d = StStall;
        end else begin
            state_d = StIdle;
        end
    end

    // Clear beats a coincident stall; the counter saturates at the limit.
    always_comb begin
        stall_cnt_d = '0;
        stall_err_d = stall_err_q;
        if (err_clr) begin
            stall_err_d = 1'b0;
        end else if (stall_cond) begin
            stall_cnt_d = (stall_cnt_q == CntW'(STALL_LIMIT)) ? stall_cnt_q
                                                                : stall_cnt_q + 1'b1;
            if (stall_cnt_d == CntW'(STALL_LIMIT)) begin
                stall_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            idx_q       <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign grant_vld = (state_q == StXfer);
    assign grant_idx = idx_q;
    assign stall_err = stall_err_q;

`ifdef ARB_STATS_EN
    logic [NUM_REQ*16-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (stats_clr) begin
                cnt_d[i*16 +: 16] = '0;
            end else if (req_rd_en[i] && cnt_q[i*16 +: 16] != 16'hFFFF) begin
                cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: reset, rotation, pointer skip, gating, watchdog, stats.
module tb_out_port_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned NR = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NR-1:0]  req_empty;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_rd_en;
    logic           out_full;
    logic           out_wr_en;
    logic [DW-1:0]  out_data;
    logic [1:0]     grant_idx;
    logic           grant_vld;
    logic           stall_err;
    logic           err_clr;
`ifdef ARB_STATS_EN
    logic           stats_clr;
    logic [NR*16-1:0] grant_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    out_port_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .STALL_LIMIT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req_empty(req_empty),
        .req_data (req_data),
        .req_rd_en(req_rd_en),
        .out_full (out_full),
        .out_wr_en(out_wr_en),
        .out_data (out_data),
        .grant_idx(grant_idx),
        .grant_vld(grant_vld),
        .stall_err(stall_err),
`ifdef ARB_STATS_EN
        .stats_clr(stats_clr),
        .grant_cnt(grant_cnt),
`endif
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, tag, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  empty;
        logic        full;
        logic [3:0]  rd;
        logic        wr;
        logic [63:0] data;
        logic        vld;
        logic [1:0]  idx;
        logic [1:0]  st;
    } vec_t;

    vec_t vt[17];

    initial begin
        // Rotation from a freshly reset pointer
        vt[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0001, 1'b1, 64'hA0, 1'b1, 2'd0, 2'd1};
        vt[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0010, 1'b1, 64'hA1, 1'b1, 2'd1, 2'd1};
        vt[2]  = '{1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 64'hA2, 1'b1, 2'd2, 2'd1};
        vt[3]  = '{1'b1, 4'b0000, 1'b0, 4'b1000, 1'b1, 64'hA3, 1'b1, 2'd3, 2'd1};
        vt[4]  = '{1'b1, 4'b0000, 1'b0, 4'b0001, 1'b1, 64'hA0, 1'b1, 2'd0, 2'd1};
        // Only requester 2 pending, then 0 and 3
        vt[5]  = '{1'b1, 4'b1011, 1'b0, 4'b0100, 1'b1, 64'hA2, 1'b1, 2'd2, 2'd1};
        vt[6]  = '{1'b1, 4'b1011, 1'b0, 4'b0100, 1'b1, 64'hA2, 1'b1, 2'd2, 2'd1};
        vt[7]  = '{1'b1, 4'b1011, 1'b0, 4'b0100, 1'b1, 64'hA2, 1'b1, 2'd2, 2'd1};
        vt[8]  = '{1'b1, 4'b0110, 1'b0, 4'b1000, 1'b1, 64'hA3, 1'b1, 2'd3, 2'd1};
        vt[9]  = '{1'b1, 4'b0110, 1'b0, 4'b0001, 1'b1, 64'hA0, 1'b1, 2'd0, 2'd1};
        // Enable gating, then resume at pointer 1
        vt[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 64'h0,  1'b0, 2'd0, 2'd0};
        vt[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 64'h0,  1'b0, 2'd0, 2'd0};
        vt[12] = '{1'b1, 4'b0000, 1'b0, 4'b0010, 1'b1, 64'hA1, 1'b1, 2'd1, 2'd1};
        // Nothing pending, full without requests, one blocked cycle, release
        vt[13] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 64'h0,  1'b0, 2'd1, 2'd0};
        vt[14] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 64'h0,  1'b0, 2'd1, 2'd0};
        vt[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0,  1'b0, 2'd1, 2'd2};
        vt[16] = '{1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 64'hA2, 1'b1, 2'd2, 2'd1};

        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 64'hA0 + 64'(i);
        rst = 1'b0; en = 1'b0; req_empty = 4'b1111; out_full = 1'b0; err_clr = 1'b0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #1;
        check("rst_vld", 0, 64'(grant_vld), 64'h0);
        check("rst_idx", 0, 64'(grant_idx), 64'h0);
        check("rst_err", 0, 64'(stall_err), 64'h0);

        // Two grants, then a mid-cycle reset while a transfer is live
        @(negedge clk); rst = 1'b1; en = 1'b1; req_empty = 4'b0000;
        @(posedge clk); @(posedge clk); #1;
        check("pre_vld", 0, 64'(grant_vld), 64'h1);
        check("pre_idx", 0, 64'(grant_idx), 64'h1);
        check("pre_wr", 0, 64'(out_wr_en), 64'h1);
        #2; rst = 1'b0; #1;
        check("arst_rd", 0, 64'(req_rd_en), 64'h0);
        check("arst_wr", 0, 64'(out_wr_en), 64'h0);
        check("arst_data", 0, out_data, 64'h0);
        check("arst_err", 0, 64'(stall_err), 64'h0);
        check("arst_vld", 0, 64'(grant_vld), 64'h0);
        check("arst_idx", 0, 64'(grant_idx), 64'h0);
        @(negedge clk); en = 1'b0;
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            en = vt[i].en; req_empty = vt[i].empty; out_full = vt[i].full;
            #1;
            check("rd_en", i, 64'(req_rd_en), 64'(vt[i].rd));
            check("wr_en", i, 64'(out_wr_en), 64'(vt[i].wr));
            check("out_data", i, out_data, vt[i].data);
            @(posedge clk); #1;
            check("grant_vld", i, 64'(grant_vld), 64'(vt[i].vld));
            check("grant_idx", i, 64'(grant_idx), 64'(vt[i].idx));
            check("state", i, 64'(dut.state_q), 64'(vt[i].st));
            check("stall_err", i, 64'(stall_err), 64'h0);
        end

        // Watchdog: requester 1 blocked by a full output buffer
        @(negedge clk); en = 1'b1; req_empty = 4'b1101; out_full = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check("wd_rd", c, 64'(req_rd_en), 64'h0);
            check("wd_wr", c, 64'(out_wr_en), 64'h0);
            @(posedge clk); #1;
            check("wd_state", c, 64'(dut.state_q), 64'h2);
            check("wd_err", c, 64'(stall_err), (c >= 4) ? 64'h1 : 64'h0);
            check("wd_cnt", c, 64'(dut.stall_cnt_q), (c >= 4) ? 64'h4 : 64'(c));
            @(negedge clk);
        end
        out_full = 1'b0; #1;
        check("wd_rel_rd", 0, 64'(req_rd_en), 64'h2);
        check("wd_rel_data", 0, out_data, 64'hA1);
        @(posedge clk); #1;
        check("wd_rel_idx", 0, 64'(grant_idx), 64'h1);
        check("wd_sticky", 0, 64'(stall_err), 64'h1);
        check("wd_rel_cnt", 0, 64'(dut.stall_cnt_q), 64'h0);
        @(negedge clk); out_full = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1;
        check("clr_err", 0, 64'(stall_err), 64'h0);
        check("clr_cnt", 0, 64'(dut.stall_cnt_q), 64'h0);
        @(negedge clk); err_clr = 1'b0;
        @(posedge clk); #1;
        check("post_clr_cnt", 0, 64'(dut.stall_cnt_q), 64'h1);
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        check("en0_cnt", 0, 64'(dut.stall_cnt_q), 64'h0);
        check("en0_state", 0, 64'(dut.state_q), 64'h0);

`ifdef ARB_STATS_EN
        @(negedge clk); out_full = 1'b0; stats_clr = 1'b1;
        @(posedge clk); #1;
        check("st_clr", 0, grant_cnt, 64'h0);
        @(negedge clk); stats_clr = 1'b0; en = 1'b1; req_empty = 4'b1110;
        repeat (3) @(posedge clk);
        #1;
        check("st_three", 0, grant_cnt, 64'h3);
        @(negedge clk); stats_clr = 1'b1;
        @(posedge clk); #1;
        check("st_clr_wins", 0, grant_cnt, 64'h0);
        @(negedge clk); stats_clr = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        check("st_fffe", 0, 64'(grant_cnt[15:0]), 64'hFFFE);
        repeat (2) @(posedge clk);
        #1;
        check("st_sat", 0, 64'(grant_cnt[15:0]), 64'hFFFF);
        check("st_others", 0, 64'(grant_cnt[63:16]), 64'h0);
        @(negedge clk); en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
